// File: rtl/pe_reg_arbiter.sv
// pe_reg_arbiter: four requesters share one output register through a
// round-robin arbiter. The register is a one-entry buffer with a
// valid/ready handshake toward the consumer. It can drain and reload on
// the same edge, so a stream of requests sees no bubble.
//
// Optional feature: define PE_ARB_PARITY_EN to add the out_parity output.
// out_parity is the even parity (XOR) of the captured slice and is stored
// alongside out_data.
module pe_reg_arbiter #(
   parameter int DATA_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          req,
   input  logic [4*DATA_W-1:0] data_in,
   output logic [3:0]          gnt,
   output logic [DATA_W-1:0]   out_data,
   output logic [1:0]          out_src,
   output logic                out_valid,
   input  logic                out_ready
`ifdef PE_ARB_PARITY_EN
   ,
   output logic                out_parity
`endif
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [1:0]        last_gnt;
   logic [1:0]        sel_idx;
   logic [1:0]        cand;
   logic [DATA_W-1:0] sel_data;
   logic              load;

   // Round-robin pick: the first requester found searching upward from last_gnt+1.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first,
      // so no path leaves it unassigned and no latch is inferred.
      sel_idx = last_gnt + 2'd1;
      cand    = '0;
      // The loop walks from the farthest candidate to the nearest one, so
      // the nearest requester is the last one written and wins.
      for (int k = 4; k >= 1; k--) begin
         cand = last_gnt + 2'(k);
         if (req[cand]) begin
            sel_idx = cand;
         end
      end
   end

   // Select the data slice of the chosen requester.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < 4; i++) begin
         if (sel_idx == 2'(i)) begin
            sel_data = data_in[i*DATA_W +: DATA_W];
         end
      end
   end

   // Next-state and load/grant decode. Reset masks the grant.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      gnt        = '0;
      if (!rst) begin
         unique case (state)
            EMPTY: begin
               load = |req;
               if (load) begin
                  state_next = FULL;
               end
            end
            FULL: begin
               // Drain and reload may happen on the same edge; the buffer stays FULL.
               load = (|req) && out_ready;
               if (out_ready && !load) begin
                  state_next = EMPTY;
               end
            end
            default: state_next = EMPTY;
         endcase
         if (load) begin
            gnt = 4'b0001 << sel_idx;
         end
      end
   end

   // State register. Reset takes priority over load and drain.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is written with non-blocking assignments,
      // so every register samples values from before the edge.
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Shared data register, source index and round-robin pointer. All of them update only on load.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data <= '0;
         out_src  <= 2'd0;
         last_gnt <= 2'd3;   // requester 0 is searched first after reset
      end else if (load) begin
         out_data <= sel_data;
         out_src  <= sel_idx;
         last_gnt <= sel_idx;
      end
   end

`ifdef PE_ARB_PARITY_EN
   // Parity of the captured slice. It is held together with out_data.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_parity <= 1'b0;
      end else if (load) begin
         out_parity <= ^sel_data;
      end
   end
`endif

   assign out_valid = (state == FULL);

endmodule

// File: tb/tb_pe_reg_arbiter.sv
// Randomized and directed bench for pe_reg_arbiter. A behavioural model of
// the one-entry buffer and the round-robin pointer predicts every grant and
// every register value.
module tb_pe_reg_arbiter;

   localparam int DW = 8;

   logic          clk;
   logic          rst;
   logic [3:0]    req;
   logic [4*DW-1:0] data_in;
   logic [3:0]    gnt;
   logic [DW-1:0] out_data;
   logic [1:0]    out_src;
   logic          out_valid;
   logic          out_ready;
`ifdef PE_ARB_PARITY_EN
   logic          out_parity;
`endif

   pe_reg_arbiter #(.DATA_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .data_in   (data_in),
      .gnt       (gnt),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef PE_ARB_PARITY_EN
      ,
      .out_parity(out_parity)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state.
   logic          m_valid;
   logic [DW-1:0] m_data;
   int            m_src;
   int            m_ptr;
   logic          m_par;

   logic [3:0]    obs_gnt;
   logic [3:0]    gnt_seq [5];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive one cycle of inputs. The grant is checked before the edge; the
   // registered outputs are checked after it.
   task automatic apply(input logic r, input logic [3:0] q, input logic [31:0] d, input logic rd);
      logic       ld;
      logic [3:0] eg;
      int         gi;
      bit         found;
      @(negedge clk);
      rst = r; req = q; data_in = d; out_ready = rd;
      #1;
      ld = !r && (q != 4'd0) && (!m_valid || rd);
      eg = 4'd0; gi = 0; found = 0;
      if (ld) begin
         for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (!found && q[c]) begin
               gi = c;
               found = 1;
            end
         end
         eg[gi] = 1'b1;
      end
      obs_gnt = gnt;
      check("gnt", {28'd0, gnt}, {28'd0, eg});
      @(posedge clk);
      if (r) begin
         m_valid = 0; m_data = '0; m_src = 0; m_ptr = 3; m_par = 0;
      end else if (ld) begin
         m_data  = d[gi*DW +: DW];
         m_src   = gi;
         m_ptr   = gi;
         m_valid = 1;
         m_par   = ^m_data;
      end else if (m_valid && rd) begin
         m_valid = 0;
      end
      #1;
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("out_data", {24'd0, out_data}, {24'd0, m_data});
      check("out_src", {30'd0, out_src}, 32'(m_src));
`ifdef PE_ARB_PARITY_EN
      check("out_parity", {31'd0, out_parity}, {31'd0, m_par});
`endif
   endtask

   initial begin
      rst = 1'b1; req = '0; data_in = '0; out_ready = 1'b0;
      m_valid = 0; m_data = '0; m_src = 0; m_ptr = 3; m_par = 0;

      // Reset: gnt must stay low even while a request is present.
      apply(1, 4'b1111, 32'hFFFF_FFFF, 1);
      apply(1, 4'b0000, 32'h0, 0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_data", {24'd0, out_data}, 32'd0);

      // Single load followed by backpressure.
      apply(0, 4'b0001, 32'h0000_00A5, 0);
      check("r26_gnt0", {28'd0, obs_gnt}, 32'h1);
      check("r26_data", {24'd0, out_data}, 32'hA5);
      check("r26_src", {30'd0, out_src}, 32'd0);
      apply(0, 4'b0001, 32'h0000_00A5, 0);
      check("r26_gnt1", {28'd0, obs_gnt}, 32'h0);
      apply(0, 4'b0001, 32'h0000_00A5, 0);
      check("r26_gnt2", {28'd0, obs_gnt}, 32'h0);

      // All four requesting with the consumer always ready: grants rotate.
      apply(1, 4'b0000, 32'h0, 0);
      for (int i = 0; i < 5; i++) begin
         apply(0, 4'b1111, 32'h4433_2211, 1);
         gnt_seq[i] = obs_gnt;
         check("r27_valid", {31'd0, out_valid}, 32'd1);
      end
      check("r27_g0", {28'd0, gnt_seq[0]}, 32'h1);
      check("r27_g1", {28'd0, gnt_seq[1]}, 32'h2);
      check("r27_g2", {28'd0, gnt_seq[2]}, 32'h4);
      check("r27_g3", {28'd0, gnt_seq[3]}, 32'h8);
      check("r27_g4", {28'd0, gnt_seq[4]}, 32'h1);

      // Backpressure while FULL with 8'h3C.
      apply(1, 4'b0000, 32'h0, 0);
      apply(0, 4'b0001, 32'h0000_003C, 0);
      for (int i = 0; i < 5; i++) begin
         apply(0, 4'b0100, 32'h005A_0000, 0);
         check("r28_hold_gnt", {28'd0, obs_gnt}, 32'h0);
         check("r28_hold_data", {24'd0, out_data}, 32'h3C);
      end
      apply(0, 4'b0100, 32'h005A_0000, 1);
      check("r28_gnt", {28'd0, obs_gnt}, 32'h4);
      check("r28_data", {24'd0, out_data}, 32'h5A);
      check("r28_src", {30'd0, out_src}, 32'd2);

      // Drain with no request, then extra ready pulses while EMPTY.
      for (int i = 0; i < 3; i++) begin
         apply(0, 4'b0000, 32'h0, 1);
         check("r29_valid", {31'd0, out_valid}, 32'd0);
         check("r29_data", {24'd0, out_data}, 32'h5A);
      end

      // Reset in the middle of a transfer discards the held data and resets the pointer.
      apply(0, 4'b0010, 32'h0000_7E00, 0);
      check("r30_full", {24'd0, out_data}, 32'h7E);
      apply(1, 4'b0010, 32'h0000_7E00, 0);
      check("r30_rst_gnt", {28'd0, obs_gnt}, 32'h0);
      check("r30_valid", {31'd0, out_valid}, 32'd0);
      check("r30_data", {24'd0, out_data}, 32'h0);
      apply(0, 4'b1010, 32'h0000_0000, 1);
      check("r30_gnt", {28'd0, obs_gnt}, 32'h2);

`ifdef PE_ARB_PARITY_EN
      apply(1, 4'b0000, 32'h0, 0);
      apply(0, 4'b0001, 32'h0000_0007, 0);
      check("r31_par7", {31'd0, out_parity}, 32'd1);
      apply(0, 4'b0010, 32'h0000_0300, 1);
      check("r31_par3", {31'd0, out_parity}, 32'd0);
`endif

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         apply(($urandom_range(0, 49) == 0),
               4'($urandom),
               $urandom,
               ($urandom_range(0, 2) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
